fir_sym_input_stage: RTL and testbench
======================================

// Module: fir_sym_input_stage
// PURPOSE
//  Parametrised input/multiply front end for the transposed-form symmetric FIR cascade.
//  Registers each accepted sample and forms one product per tap from a folded coefficient bank.
//  The bank holds NUNIQ=(NTAPS+1)/2 unique coefficients and is runtime-loadable through a double buffer.
//  Products feed the downstream tap-delay/adder chain as one flat, registered bus.
// PARAMETERS
//  IN_W      10        sample width, signed (sfix, En IN_W-1)
//  COEF_W    10        coefficient width, signed (En9 at default)
//  NTAPS     19        filter length; unique index u(k)=min(k,NTAPS-1-k)
//  PROD_W    20        per-tap product width on the output bus
//  SHIFT     0         arithmetic right shift (truncation) applied to the full product
//  COEF_INIT {1,0,-3,0,13,1,-40,-1,157,258}  flat NUNIQ*COEF_W reset value; entry u at bits [u*COEF_W +: COEF_W]
// PORTS
//  clk         in   1              rising-edge clock
//  reset       in   1              synchronous, active-high
//  clk_enable  in   1              global stall; 0 freezes every pipeline register
//  in_valid    in   1              filter_in qualifier
//  filter_in   in   IN_W           input sample, signed
//  coef_we     in   1              shadow-bank write strobe
//  coef_addr   in   clog2(NUNIQ)   unique-coefficient index
//  coef_wdata  in   COEF_W         coefficient value, signed
//  coef_swap   in   1              request: copy shadow bank to active bank
//  coef_busy   out  1              swap pending; writes are ignored while high
//  swap_ack    out  1              one-cycle pulse on the edge the copy happens
//  products    out  NTAPS*PROD_W   tap k at bits [k*PROD_W +: PROD_W], signed
//  out_valid   out  1              products qualifier
// BEHAVIOUR
//  Reset (sync): inputreg=0, in_vld_q=0, products=0, out_valid=0, coef_busy=0, swap_ack=0.
//   Active and shadow banks are both loaded from COEF_INIT.
//  Stage 1, edge with clk_enable=1: inputreg<=filter_in and in_vld_q<=in_valid.
//   inputreg is loaded only when in_valid=1; it holds otherwise.
//  Stage 2, same edge with clk_enable=1:
//   - products[k] <= resize((inputreg*active[u(k)]) >>> SHIFT).
//   - out_valid <= in_vld_q.
//   - Latency: a sample accepted at edge N gives out_valid=1 after edge N+1, for exactly one enabled cycle.
//  clk_enable=0: all stage registers hold; out_valid holds its value and is not re-asserted.
//  Arithmetic:
//   - Full product is IN_W+COEF_W bits, signed. Shifting by SHIFT truncates toward -inf.
//   - resize: sign-extend if wider than PROD_W; otherwise wrap (keep the PROD_W LSBs).
//  Coefficient writes:
//   - coef_we=1 and coef_busy=0: shadow[coef_addr]<=coef_wdata on that edge, independent of clk_enable.
//   - coef_addr>=NUNIQ: write is ignored.
//  Swap FSM, two states:
//   - IDLE -> PEND on coef_swap=1 (coef_busy=1). coef_swap in PEND has no effect.
//   - PEND -> IDLE on the first later edge with clk_enable=1. On that edge active<=shadow and swap_ack=1.
//  Swap timing:
//   - Products registered on the copy edge use the OLD bank; the next enabled edge uses the new bank.
//   - coef_we together with coef_swap in the same cycle: the write lands in shadow and is included in the copy.
//   - coef_we during PEND: dropped.
//  Reset during PEND: returns to IDLE, and both banks revert to COEF_INIT.
// CONFIGURATION
//  PROD_SAT_EN defined:
//   - resize saturates to [-2^(PROD_W-1), 2^(PROD_W-1)-1] instead of wrapping.
//   - Adds output sat_flag (1 bit), registered with products: OR over taps of "saturated this sample"; reset 0.
//  PROD_SAT_EN undefined: wrap only; no sat_flag port.
// TESTING
//  1 Reset: assert reset for 2 cycles mid-stream -> products=0, out_valid=0, coef_busy=0; the next impulse yields the COEF_INIT values.
//  2 Impulse: filter_in=1 for one valid cycle, defaults -> after 2 edges tap9=258, taps 8/10=157, taps 6/12=-40, taps 0/18=1, out_valid high for 1 cycle.
//  3 Extreme: filter_in=-512, defaults -> tap9=-132096, tap6=20480, no overflow.
//  4 Stall: clk_enable=0 for 3 cycles while a sample is in stage 1 -> products and out_valid frozen; result emerges on the 2nd enabled edge.
//  5 Reload:
//     - Write shadow[9]=100, pulse coef_swap with clk_enable=0 -> coef_busy stays high, writes are ignored.
//     - Raise clk_enable -> swap_ack pulses; the next sample with filter_in=2 gives tap9=200.
//  6 PROD_W=16, SHIFT=0, filter_in=-512, tap9 coefficient 258:
//     - wrap build -> tap9=-1024.
//     - PROD_SAT_EN build -> tap9=-32768 and sat_flag=1.

Source files
------------

// File: rtl/fir_sym_input_stage_if.sv
// fir_sym_input_stage_if
//   Bundles the sample, coefficient-load and product signals of the
//   symmetric FIR input stage.
//   master : drives samples and coefficient traffic, observes products/status
//   slave  : the input stage itself
//   Signals:
//     in_valid, filter_in        sample qualifier and signed sample
//     coef_we, coef_addr,        shadow-bank write port (unique-coefficient index)
//     coef_wdata
//     coef_swap                  request shadow -> active copy
//     coef_busy, swap_ack        swap pending / copy-done pulse
//     products, out_valid        flat per-tap product bus and its qualifier
//     sat_flag                   only with PROD_SAT_EN: some tap saturated
//   Optional feature macro: PROD_SAT_EN
interface fir_sym_input_stage_if #(
    parameter int IN_W   = 10,
    parameter int COEF_W = 10,
    parameter int NTAPS  = 19,
    parameter int PROD_W = 20
);
    localparam int NUNIQ = (NTAPS + 1) / 2;
    localparam int AW    = (NUNIQ > 1) ? $clog2(NUNIQ) : 1;

    logic                     in_valid;
    logic signed [IN_W-1:0]   filter_in;
    logic                     coef_we;
    logic [AW-1:0]            coef_addr;
    logic signed [COEF_W-1:0] coef_wdata;
    logic                     coef_swap;
    logic                     coef_busy;
    logic                     swap_ack;
    logic [NTAPS*PROD_W-1:0]  products;
    logic                     out_valid;

`ifdef PROD_SAT_EN
    logic                     sat_flag;

    modport master (
        output in_valid, filter_in, coef_we, coef_addr, coef_wdata, coef_swap,
        input  coef_busy, swap_ack, products, out_valid, sat_flag
    );
    modport slave (
        input  in_valid, filter_in, coef_we, coef_addr, coef_wdata, coef_swap,
        output coef_busy, swap_ack, products, out_valid, sat_flag
    );
`else
    modport master (
        output in_valid, filter_in, coef_we, coef_addr, coef_wdata, coef_swap,
        input  coef_busy, swap_ack, products, out_valid
    );
    modport slave (
        input  in_valid, filter_in, coef_we, coef_addr, coef_wdata, coef_swap,
        output coef_busy, swap_ack, products, out_valid
    );
`endif
endinterface

// File: rtl/fir_sym_input_stage.sv
// fir_sym_input_stage
//   Input/multiply front end of a transposed-form symmetric FIR. Each accepted
//   sample is registered, then multiplied by the folded coefficient of every
//   tap (tap k uses unique entry min(k, NTAPS-1-k)). The coefficient bank is
//   double buffered: writes go to a shadow bank, a swap request copies it to
//   the active bank on the next enabled edge.
//   Ports:
//     clk, reset      rising-edge clock, synchronous active-high reset
//     clk_enable      global stall; 0 freezes the sample/product pipeline
//     bus (slave)     samples, coefficient load, swap handshake, products
//   Optional feature macro: PROD_SAT_EN
//     defined   -> products saturate to PROD_W, bus.sat_flag reports it
//     undefined -> products wrap to PROD_W

// One tap: full-precision signed multiply, shift, resize, register.
module fir_sym_input_stage_tap #(
    parameter int IN_W   = 10,
    parameter int COEF_W = 10,
    parameter int PROD_W = 20,
    parameter int SHIFT  = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic signed [IN_W-1:0]   sample,
    input  logic signed [COEF_W-1:0] coef,
    output logic [PROD_W-1:0]        prod
`ifdef PROD_SAT_EN
    ,
    output logic                     ovf
`endif
);
    localparam int FULL_W = IN_W + COEF_W;

    logic signed [FULL_W-1:0] full;
    logic signed [FULL_W-1:0] shd;
    logic [PROD_W-1:0]        res;

    assign full = FULL_W'(sample) * FULL_W'(coef);
    // Arithmetic shift floors, i.e. truncates toward -inf.
    assign shd  = full >>> SHIFT;

`ifdef PROD_SAT_EN
    if (FULL_W > PROD_W) begin : g_sat
        // Representable iff every bit from the new sign bit upward agrees.
        logic [FULL_W-PROD_W:0] hi;
        assign hi  = shd[FULL_W-1:PROD_W-1];
        assign ovf = !((&hi) || !(|hi));
        assign res = ovf ? {shd[FULL_W-1], {(PROD_W-1){~shd[FULL_W-1]}}}
                         : PROD_W'(shd);
    end else begin : g_fit
        assign ovf = 1'b0;
        assign res = PROD_W'(shd);
    end
`else
    // Size cast sign-extends when widening and keeps the LSBs when narrowing.
    assign res = PROD_W'(shd);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            prod <= '0;
        end else if (en) begin
            prod <= res;
        end
    end
endmodule

module fir_sym_input_stage #(
    parameter int IN_W   = 10,
    parameter int COEF_W = 10,
    parameter int NTAPS  = 19,
    parameter int PROD_W = 20,
    parameter int SHIFT  = 0,
    parameter logic [((NTAPS+1)/2)*COEF_W-1:0] COEF_INIT = {
        10'sd258, 10'sd157, -10'sd1, -10'sd40, 10'sd1,
        10'sd13,  10'sd0,   -10'sd3, 10'sd0,   10'sd1
    }
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clk_enable,
    fir_sym_input_stage_if.slave bus
);
    localparam int NUNIQ  = (NTAPS + 1) / 2;
    localparam int STAGES = 2;

    typedef enum logic {IDLE, PEND} swap_state_t;

    swap_state_t                  state;
    logic [NUNIQ-1:0][COEF_W-1:0] active;
    logic [NUNIQ-1:0][COEF_W-1:0] shadow;
    logic                         coef_busy;
    logic                         swap_ack;
    logic                         wr_ok;

    logic signed [IN_W-1:0]       inputreg;
    logic [STAGES:1]              vld_pipe;
    logic [NTAPS-1:0][PROD_W-1:0] prod_q;

    // Stage 1: sample register loads only on valid; the valid bit always shifts.
    always_ff @(posedge clk) begin
        if (reset) begin
            inputreg <= '0;
            vld_pipe <= '0;
        end else if (clk_enable) begin
            if (bus.in_valid) begin
                inputreg <= bus.filter_in;
            end
            vld_pipe <= {vld_pipe[STAGES-1:1], bus.in_valid};
        end
    end

    assign wr_ok = bus.coef_we && (int'(bus.coef_addr) < NUNIQ);

    // Swap FSM and both banks. Shadow writes ignore clk_enable; the copy
    // waits for an enabled edge so it lines up with a product update.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            coef_busy <= 1'b0;
            swap_ack  <= 1'b0;
            active    <= COEF_INIT;
            shadow    <= COEF_INIT;
        end else begin
            swap_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_ok) begin
                        shadow[bus.coef_addr] <= bus.coef_wdata;
                    end
                    if (bus.coef_swap) begin
                        state     <= PEND;
                        coef_busy <= 1'b1;
                    end
                end
                PEND: begin
                    if (clk_enable) begin
                        active    <= shadow;
                        state     <= IDLE;
                        coef_busy <= 1'b0;
                        swap_ack  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PROD_SAT_EN
    logic [NTAPS-1:0] ovf;
    logic             sat_q;
`endif

    // Stage 2: one multiplier per tap reading the active bank. On the copy
    // edge the taps still see the old bank.
    for (genvar k = 0; k < NTAPS; k++) begin : g_tap
        localparam int U = (k < NTAPS - 1 - k) ? k : NTAPS - 1 - k;
        fir_sym_input_stage_tap #(
            .IN_W   (IN_W),
            .COEF_W (COEF_W),
            .PROD_W (PROD_W),
            .SHIFT  (SHIFT)
        ) u_tap (
            .clk    (clk),
            .reset  (reset),
            .en     (clk_enable),
            .sample (inputreg),
            .coef   (active[U]),
            .prod   (prod_q[k])
`ifdef PROD_SAT_EN
            ,
            .ovf    (ovf[k])
`endif
        );
    end

`ifdef PROD_SAT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            sat_q <= 1'b0;
        end else if (clk_enable) begin
            sat_q <= |ovf;
        end
    end
    assign bus.sat_flag = sat_q;
`endif

    assign bus.products  = prod_q;
    assign bus.out_valid = vld_pipe[STAGES];
    assign bus.coef_busy = coef_busy;
    assign bus.swap_ack  = swap_ack;
endmodule

// File: tb/tb_fir_sym_input_stage.sv
// Bench for fir_sym_input_stage: a default-width DUT and a PROD_W=16 DUT share
// the same stimulus; a cycle-level reference model predicts both.
module tb_fir_sym_input_stage;
    localparam int IN_W   = 10;
    localparam int COEF_W = 10;
    localparam int NTAPS  = 19;
    localparam int PROD_W = 20;
    localparam int NPW    = 16;
    localparam int NUNIQ  = 10;
    localparam int AW     = 4;

    logic clk;
    logic reset;
    logic clk_enable;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fir_sym_input_stage_if #(.IN_W(IN_W), .COEF_W(COEF_W), .NTAPS(NTAPS), .PROD_W(PROD_W)) bus();
    fir_sym_input_stage_if #(.IN_W(IN_W), .COEF_W(COEF_W), .NTAPS(NTAPS), .PROD_W(NPW))    nbus();

    assign nbus.in_valid   = bus.in_valid;
    assign nbus.filter_in  = bus.filter_in;
    assign nbus.coef_we    = bus.coef_we;
    assign nbus.coef_addr  = bus.coef_addr;
    assign nbus.coef_wdata = bus.coef_wdata;
    assign nbus.coef_swap  = bus.coef_swap;

    fir_sym_input_stage #(.IN_W(IN_W), .COEF_W(COEF_W), .NTAPS(NTAPS), .PROD_W(PROD_W), .SHIFT(0)) dut (
        .clk(clk), .reset(reset), .clk_enable(clk_enable), .bus(bus));
    fir_sym_input_stage #(.IN_W(IN_W), .COEF_W(COEF_W), .NTAPS(NTAPS), .PROD_W(NPW), .SHIFT(0)) dut_n (
        .clk(clk), .reset(reset), .clk_enable(clk_enable), .bus(nbus));

    // Reference model state
    int  m_init [NUNIQ] = '{1, 0, -3, 0, 13, 1, -40, -1, 157, 258};
    int  m_act  [NUNIQ];
    int  m_shd  [NUNIQ];
    int  m_smp;
    bit  m_vq;
    bit  m_pend;
    logic [NTAPS*PROD_W-1:0] e_prod;
    logic [NTAPS*NPW-1:0]    e_nprod;
    bit  e_ov, e_busy, e_ack, e_sat;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    function automatic int uidx(int k);
        return (k < NTAPS - 1 - k) ? k : NTAPS - 1 - k;
    endfunction

    function automatic int tapv(logic [NTAPS*PROD_W-1:0] v, int k);
        logic signed [PROD_W-1:0] t;
        t = v[k*PROD_W +: PROD_W];
        return int'(t);
    endfunction

    function automatic int ntapv(logic [NTAPS*NPW-1:0] v, int k);
        logic signed [NPW-1:0] t;
        t = v[k*NPW +: NPW];
        return int'(t);
    endfunction

    // Products every tap would register from the current sample and bank.
    task automatic model_products();
        longint p, hi, lo;
        bit     s;
        s  = 1'b0;
        hi = (longint'(1) <<< (NPW - 1)) - 1;
        lo = -hi - 1;
        for (int k = 0; k < NTAPS; k++) begin
            p = longint'(m_smp) * longint'(m_act[uidx(k)]);
            e_prod[k*PROD_W +: PROD_W] = PROD_W'(p);
            if (p > hi || p < lo) s = 1'b1;
`ifdef PROD_SAT_EN
            if (p > hi) p = hi;
            else if (p < lo) p = lo;
`endif
            e_nprod[k*NPW +: NPW] = NPW'(p);
        end
        e_sat = s;
    endtask

    // Drive one cycle of inputs, advance the model, then sample 1 time unit after the edge.
    task automatic step(bit en, bit rst, bit iv, int x, bit we, int addr, int data, bit sw);
        reset          = rst;
        clk_enable     = en;
        bus.in_valid   = iv;
        bus.filter_in  = IN_W'(x);
        bus.coef_we    = we;
        bus.coef_addr  = AW'(addr);
        bus.coef_wdata = COEF_W'(data);
        bus.coef_swap  = sw;
        if (rst) begin
            m_smp = 0; m_vq = 0; m_pend = 0;
            e_prod = '0; e_nprod = '0; e_ov = 0; e_ack = 0; e_sat = 0;
            m_act = m_init; m_shd = m_init;
        end else begin
            if (en) begin
                model_products();
                e_ov = m_vq;
                if (iv) m_smp = x;
                m_vq = iv;
            end
            e_ack = 1'b0;
            if (!m_pend) begin
                if (we && addr < NUNIQ) m_shd[addr] = data;
                if (sw) m_pend = 1'b1;
            end else if (en) begin
                m_act  = m_shd;
                m_pend = 1'b0;
                e_ack  = 1'b1;
            end
        end
        e_busy = m_pend;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1, 1, 1, 5, 0, 0, 0, 0);
        step(1, 1, 1, 5, 0, 0, 0, 0);
        chk_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else pass_cnt++;
        chk_cnt++; if (bus.products !== '0) $display("FAIL reset_products: got %h want 0", bus.products); else pass_cnt++;
        chk_cnt++; if (bus.coef_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.coef_busy); else pass_cnt++;
        chk_cnt++; if (bus.swap_ack !== 1'b0) $display("FAIL reset_ack: got %b want 0", bus.swap_ack); else pass_cnt++;
    endtask

    task automatic test_impulse();
        step(1, 0, 1, 1, 0, 0, 0, 0);
        chk_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL impulse_early_valid: got %b want 0", bus.out_valid); else pass_cnt++;
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk_cnt++; if (bus.out_valid !== 1'b1) $display("FAIL impulse_valid: got %b want 1", bus.out_valid); else pass_cnt++;
        chk_cnt++; if (bus.products !== e_prod) $display("FAIL impulse_products: got %h want %h", bus.products, e_prod); else pass_cnt++;
        chk_cnt++; if (tapv(bus.products, 9) !== 258) $display("FAIL impulse_tap9: got %0d want 258", tapv(bus.products, 9)); else pass_cnt++;
        chk_cnt++; if (tapv(bus.products, 8) !== 157 || tapv(bus.products, 10) !== 157)
            $display("FAIL impulse_tap8_10: got %0d/%0d want 157", tapv(bus.products, 8), tapv(bus.products, 10)); else pass_cnt++;
        chk_cnt++; if (tapv(bus.products, 6) !== -40 || tapv(bus.products, 12) !== -40)
            $display("FAIL impulse_tap6_12: got %0d/%0d want -40", tapv(bus.products, 6), tapv(bus.products, 12)); else pass_cnt++;
        chk_cnt++; if (tapv(bus.products, 0) !== 1 || tapv(bus.products, 18) !== 1)
            $display("FAIL impulse_tap0_18: got %0d/%0d want 1", tapv(bus.products, 0), tapv(bus.products, 18)); else pass_cnt++;
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL impulse_valid_drop: got %b want 0", bus.out_valid); else pass_cnt++;
    endtask

    task automatic test_extreme();
        step(1, 0, 1, -512, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk_cnt++; if (tapv(bus.products, 9) !== -132096) $display("FAIL extreme_tap9: got %0d want -132096", tapv(bus.products, 9)); else pass_cnt++;
        chk_cnt++; if (tapv(bus.products, 6) !== 20480) $display("FAIL extreme_tap6: got %0d want 20480", tapv(bus.products, 6)); else pass_cnt++;
        chk_cnt++; if (bus.products !== e_prod) $display("FAIL extreme_products: got %h want %h", bus.products, e_prod); else pass_cnt++;
        chk_cnt++; if (nbus.products !== e_nprod) $display("FAIL extreme_narrow_products: got %h want %h", nbus.products, e_nprod); else pass_cnt++;
`ifdef PROD_SAT_EN
        chk_cnt++; if (ntapv(nbus.products, 9) !== -32768) $display("FAIL extreme_narrow_tap9: got %0d want -32768", ntapv(nbus.products, 9)); else pass_cnt++;
        chk_cnt++; if (nbus.sat_flag !== 1'b1) $display("FAIL extreme_sat_flag: got %b want 1", nbus.sat_flag); else pass_cnt++;
        chk_cnt++; if (bus.sat_flag !== 1'b0) $display("FAIL extreme_wide_sat_flag: got %b want 0", bus.sat_flag); else pass_cnt++;
`else
        chk_cnt++; if (ntapv(nbus.products, 9) !== -1024) $display("FAIL extreme_narrow_tap9: got %0d want -1024", ntapv(nbus.products, 9)); else pass_cnt++;
`endif
    endtask

    task automatic test_stall();
        int a, b;
        a = int'($urandom_range(1, 511));
        b = -a;
        step(1, 0, 1, a, 0, 0, 0, 0);
        step(1, 0, 1, b, 0, 0, 0, 0);
        chk_cnt++; if (bus.out_valid !== 1'b1) $display("FAIL stall_pre_valid: got %b want 1", bus.out_valid); else pass_cnt++;
        chk_cnt++; if (tapv(bus.products, 9) !== a * 258) $display("FAIL stall_pre_tap9: got %0d want %0d", tapv(bus.products, 9), a * 258); else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, int'($urandom_range(0, 1023)) - 512, 0, 0, 0, 0);
            chk_cnt++; if (bus.out_valid !== 1'b1) $display("FAIL stall_hold_valid: got %b want 1", bus.out_valid); else pass_cnt++;
            chk_cnt++; if (bus.products !== e_prod) $display("FAIL stall_hold_products: got %h want %h", bus.products, e_prod); else pass_cnt++;
        end
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk_cnt++; if (bus.out_valid !== 1'b1) $display("FAIL stall_post_valid: got %b want 1", bus.out_valid); else pass_cnt++;
        chk_cnt++; if (tapv(bus.products, 9) !== b * 258) $display("FAIL stall_post_tap9: got %0d want %0d", tapv(bus.products, 9), b * 258); else pass_cnt++;
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL stall_valid_drop: got %b want 0", bus.out_valid); else pass_cnt++;
    endtask

    task automatic test_reload();
        step(1, 0, 1, 7, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 9, 100, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        chk_cnt++; if (bus.coef_busy !== 1'b1) $display("FAIL reload_busy: got %b want 1", bus.coef_busy); else pass_cnt++;
        step(0, 0, 0, 0, 1, 9, 55, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        chk_cnt++; if (bus.coef_busy !== 1'b1 || bus.swap_ack !== 1'b0)
            $display("FAIL reload_pend_hold: got busy=%b ack=%b want busy=1 ack=0", bus.coef_busy, bus.swap_ack); else pass_cnt++;
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk_cnt++; if (bus.swap_ack !== 1'b1 || bus.coef_busy !== 1'b0)
            $display("FAIL reload_copy: got ack=%b busy=%b want ack=1 busy=0", bus.swap_ack, bus.coef_busy); else pass_cnt++;
        chk_cnt++; if (tapv(bus.products, 9) !== 1806) $display("FAIL reload_old_bank: got %0d want 1806", tapv(bus.products, 9)); else pass_cnt++;
        step(1, 0, 1, 2, 0, 0, 0, 0);
        chk_cnt++; if (bus.swap_ack !== 1'b0) $display("FAIL reload_ack_pulse: got %b want 0", bus.swap_ack); else pass_cnt++;
        chk_cnt++; if (tapv(bus.products, 9) !== 700) $display("FAIL reload_new_bank: got %0d want 700", tapv(bus.products, 9)); else pass_cnt++;
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk_cnt++; if (tapv(bus.products, 9) !== 200) $display("FAIL reload_tap9: got %0d want 200", tapv(bus.products, 9)); else pass_cnt++;
        chk_cnt++; if (bus.products !== e_prod || bus.out_valid !== 1'b1)
            $display("FAIL reload_products: got %h v=%b want %h v=1", bus.products, bus.out_valid, e_prod); else pass_cnt++;
    endtask

    task automatic test_same_cycle_write();
        int d0, d3, x;
        d0 = int'($urandom_range(0, 1023)) - 512;
        d3 = int'($urandom_range(0, 1023)) - 512;
        x  = int'($urandom_range(0, 1023)) - 512;
        step(1, 0, 0, 0, 1, 12, 99, 0);
        step(1, 0, 0, 0, 1, 0, d0, 0);
        step(1, 0, 0, 0, 1, 3, d3, 1);
        step(1, 0, 1, x, 0, 0, 0, 0);
        chk_cnt++; if (bus.swap_ack !== 1'b1) $display("FAIL same_cycle_ack: got %b want 1", bus.swap_ack); else pass_cnt++;
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk_cnt++; if (tapv(bus.products, 3) !== x * d3) $display("FAIL same_cycle_tap3: got %0d want %0d", tapv(bus.products, 3), x * d3); else pass_cnt++;
        chk_cnt++; if (bus.products !== e_prod) $display("FAIL same_cycle_products: got %h want %h", bus.products, e_prod); else pass_cnt++;
        chk_cnt++; if (nbus.products !== e_nprod) $display("FAIL same_cycle_narrow: got %h want %h", nbus.products, e_nprod); else pass_cnt++;
    endtask

    task automatic test_random();
        bit en, rst, iv, we, sw;
        int x, addr, data;
        for (int i = 0; i < 300; i++) begin
            en   = ($urandom_range(0, 3) != 0);
            rst  = ($urandom_range(0, 63) == 0);
            iv   = $urandom_range(0, 1);
            we   = ($urandom_range(0, 2) == 0);
            sw   = ($urandom_range(0, 15) == 0);
            x    = int'($urandom_range(0, 1023)) - 512;
            addr = int'($urandom_range(0, 15));
            data = int'($urandom_range(0, 1023)) - 512;
            step(en, rst, iv, x, we, addr, data, sw);
            chk_cnt++; if (bus.out_valid !== e_ov) $display("FAIL rand_valid[%0d]: got %b want %b", i, bus.out_valid, e_ov); else pass_cnt++;
            chk_cnt++; if (bus.products !== e_prod) $display("FAIL rand_products[%0d]: got %h want %h", i, bus.products, e_prod); else pass_cnt++;
            chk_cnt++; if (nbus.products !== e_nprod) $display("FAIL rand_narrow[%0d]: got %h want %h", i, nbus.products, e_nprod); else pass_cnt++;
            chk_cnt++; if (bus.coef_busy !== e_busy || bus.swap_ack !== e_ack)
                $display("FAIL rand_swap[%0d]: got busy=%b ack=%b want busy=%b ack=%b", i, bus.coef_busy, bus.swap_ack, e_busy, e_ack); else pass_cnt++;
`ifdef PROD_SAT_EN
            chk_cnt++; if (nbus.sat_flag !== e_sat) $display("FAIL rand_sat[%0d]: got %b want %b", i, nbus.sat_flag, e_sat); else pass_cnt++;
`endif
        end
    endtask

    task automatic test_reset_midstream();
        step(1, 0, 1, 5, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 9, 5, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 1, 1, 3, 0, 0, 0, 0);
        step(0, 1, 1, 3, 0, 0, 0, 0);
        chk_cnt++; if (bus.products !== '0 || bus.out_valid !== 1'b0)
            $display("FAIL midreset_out: got %h v=%b want 0 v=0", bus.products, bus.out_valid); else pass_cnt++;
        chk_cnt++; if (bus.coef_busy !== 1'b0) $display("FAIL midreset_busy: got %b want 0", bus.coef_busy); else pass_cnt++;
        step(1, 0, 1, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk_cnt++; if (tapv(bus.products, 9) !== 258) $display("FAIL midreset_active: got %0d want 258", tapv(bus.products, 9)); else pass_cnt++;
        step(1, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk_cnt++; if (tapv(bus.products, 9) !== 258) $display("FAIL midreset_shadow: got %0d want 258", tapv(bus.products, 9)); else pass_cnt++;
        chk_cnt++; if (bus.products !== e_prod) $display("FAIL midreset_products: got %h want %h", bus.products, e_prod); else pass_cnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_impulse();
        test_extreme();
        test_stall();
        test_reload();
        test_same_cycle_write();
        test_random();
        test_reset_midstream();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
